ysyx_22041752_csr_unit: RTL and testbench

Machine-mode CSR unit for the ysyx_22041752 core, parametrised in XLEN. It holds mstatus/mie/mip/mtvec/mepc/mcause/mtval/mscratch and performs CSRRW/CSRRS/CSRRC accesses from the execute stage. It also performs hardware trap entry and `mret` state updates, and runs interrupt arbitration for software, timer and external sources with vectored-mode trap targets. It sits beside the execute stage and feeds trap/return PCs to the fetch redirect logic.

---
 rtl/ysyx_22041752_csr_unit_if.sv | 22 ++
 rtl/ysyx_22041752_csr_unit.sv | 200 ++++++++++++++++++++
 tb/tb_ysyx_22041752_csr_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041752_csr_unit_if.sv
// CSR access bus between the execute stage (master) and the CSR unit (slave).
// The XLEN parameter must match the one given to the CSR unit.
interface ysyx_22041752_csr_unit_if #(
    parameter int XLEN = 64
);
    logic            csr_en;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_en, csr_op, csr_addr, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_en, csr_op, csr_addr, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/ysyx_22041752_csr_unit.sv
// Machine-mode CSR unit: mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mtval,
// CSRRW/CSRRS/CSRRC accesses, trap entry, mret and interrupt arbitration.
// Define YSYX_22041752_CSR_COUNTERS_EN to add mcycle (0xB00) and minstret (0xB02).
// Update priority on a shared register: trap entry > mret > CSR write.
module ysyx_22041752_csr_unit #(
    parameter int XLEN      = 64,
    parameter int VECTOR_EN = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ysyx_22041752_csr_unit_if.slave csr_bus,
    input  logic                    exc_valid,
    input  logic                    exc_is_int,
    input  logic [3:0]              exc_code,
    input  logic [XLEN-1:0]         exc_pc,
    input  logic [XLEN-1:0]         exc_tval,
    input  logic                    mret,
    output logic [XLEN-1:0]         trap_pc,
    output logic [XLEN-1:0]         mret_pc,
    input  logic [2:0]              irq_i,
    output logic                    int_req,
    output logic [3:0]              int_code,
    input  logic                    instret
);

    // SXL/UXL = 2 on RV64, MPP hard-wired to machine mode on both widths.
    localparam logic [XLEN-1:0] MSTATUS_RST = (XLEN == 64) ? XLEN'(64'h0000_000A_0000_1800)
                                                           : XLEN'(32'h0000_1800);
    localparam logic [XLEN-1:0] LOW2_CLR    = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] MTVEC_MASK  = (VECTOR_EN != 0) ? {XLEN{1'b1}} : LOW2_CLR;

    logic            st_mie;
    logic            st_mpie;
    logic [XLEN-1:0] mie_r;
    logic [XLEN-1:0] mtvec_r;
    logic [XLEN-1:0] mscratch_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] mcause_r;
    logic [XLEN-1:0] mtval_r;
    logic [2:0]      mip_r;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mip_val;
    logic [XLEN-1:0] rdata_raw;
    logic            addr_ok;
    logic [XLEN-1:0] wval;
    logic            wr_en;
    logic [2:0]      pend;
    logic [XLEN-1:0] tvec_base;

`ifdef YSYX_22041752_CSR_COUNTERS_EN
    logic [XLEN-1:0] mcycle_r;
    logic [XLEN-1:0] minstret_r;
`endif

    // Architectural views of the packed status and pending registers.
    always_comb begin
        mstatus_val     = MSTATUS_RST;
        mstatus_val[3]  = st_mie;
        mstatus_val[7]  = st_mpie;
        mip_val         = '0;
        mip_val[3]      = mip_r[0];
        mip_val[7]      = mip_r[1];
        mip_val[11]     = mip_r[2];
    end

    // Address decode and old-value read mux.
    always_comb begin
        addr_ok   = 1'b1;
        rdata_raw = '0;
        case (csr_bus.csr_addr)
            12'h300: rdata_raw = mstatus_val;
            12'h304: rdata_raw = mie_r;
            12'h305: rdata_raw = mtvec_r;
            12'h340: rdata_raw = mscratch_r;
            12'h341: rdata_raw = mepc_r;
            12'h342: rdata_raw = mcause_r;
            12'h343: rdata_raw = mtval_r;
            12'h344: rdata_raw = mip_val;
`ifdef YSYX_22041752_CSR_COUNTERS_EN
            12'hB00: rdata_raw = mcycle_r;
            12'hB02: rdata_raw = minstret_r;
`endif
            default: addr_ok = 1'b0;
        endcase
    end

    assign csr_bus.csr_rdata   = addr_ok ? rdata_raw : '0;
    assign csr_bus.csr_illegal = csr_bus.csr_en & ~addr_ok;

    // New value for a CSRRW/CSRRS/CSRRC; op 00 leaves the register as is.
    always_comb begin
        case (csr_bus.csr_op)
            2'b01:   wval = csr_bus.csr_wdata;
            2'b10:   wval = rdata_raw | csr_bus.csr_wdata;
            2'b11:   wval = rdata_raw & ~csr_bus.csr_wdata;
            default: wval = rdata_raw;
        endcase
    end

    assign wr_en = csr_bus.csr_en & addr_ok & (csr_bus.csr_op != 2'b00);

    // mstatus MIE/MPIE: trap entry, then mret, then software write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
        end else if (exc_valid) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (wr_en && csr_bus.csr_addr == 12'h300) begin
            st_mie  <= wval[3];
            st_mpie <= wval[7];
        end
    end

    // Trap-captured registers: trap entry overrides a same-cycle write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mepc_r   <= '0;
            mcause_r <= '0;
            mtval_r  <= '0;
        end else if (exc_valid) begin
            mepc_r   <= exc_pc & LOW2_CLR;
            mcause_r <= {exc_is_int, {(XLEN-5){1'b0}}, exc_code};
            mtval_r  <= exc_tval;
        end else if (wr_en) begin
            if (csr_bus.csr_addr == 12'h341) mepc_r   <= wval & LOW2_CLR;
            if (csr_bus.csr_addr == 12'h342) mcause_r <= wval;
            if (csr_bus.csr_addr == 12'h343) mtval_r  <= wval;
        end
    end

    // Software-only registers; these still accept writes during a trap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mie_r      <= '0;
            mtvec_r    <= '0;
            mscratch_r <= '0;
        end else if (wr_en) begin
            if (csr_bus.csr_addr == 12'h304) mie_r      <= wval;
            if (csr_bus.csr_addr == 12'h305) mtvec_r    <= wval & MTVEC_MASK;
            if (csr_bus.csr_addr == 12'h340) mscratch_r <= wval;
        end
    end

    // Interrupt lines are sampled every cycle; mip ignores CSR writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mip_r <= '0;
        end else begin
            mip_r <= irq_i;
        end
    end

`ifdef YSYX_22041752_CSR_COUNTERS_EN
    // Free-running counters; a CSR write wins over the increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcycle_r   <= '0;
            minstret_r <= '0;
        end else begin
            if (wr_en && csr_bus.csr_addr == 12'hB00) mcycle_r <= wval;
            else                                      mcycle_r <= mcycle_r + 1'b1;
            if (wr_en && csr_bus.csr_addr == 12'hB02) minstret_r <= wval;
            else if (instret)                         minstret_r <= minstret_r + 1'b1;
        end
    end
`else
    logic unused_instret;
    assign unused_instret = instret;
`endif

    assign pend    = {mip_r[2] & mie_r[11], mip_r[1] & mie_r[7], mip_r[0] & mie_r[3]};
    assign int_req = st_mie & (|pend);

    // Fixed priority: external > software > timer.
    always_comb begin
        if (pend[2])      int_code = 4'd11;
        else if (pend[0]) int_code = 4'd3;
        else if (pend[1]) int_code = 4'd7;
        else              int_code = 4'd0;
    end

    assign tvec_base = mtvec_r & LOW2_CLR;

    // Vectored mode only offsets interrupts; exceptions always use the base.
    always_comb begin
        if ((VECTOR_EN != 0) && (mtvec_r[1:0] == 2'b01) && exc_is_int)
            trap_pc = tvec_base + {{(XLEN-6){1'b0}}, exc_code, 2'b00};
        else
            trap_pc = tvec_base;
    end

    assign mret_pc = mepc_r;

endmodule

// File: tb/tb_ysyx_22041752_csr_unit.sv
// Self-checking bench for ysyx_22041752_csr_unit (XLEN=64, VECTOR_EN=1).
// Define YSYX_22041752_CSR_COUNTERS_EN to also exercise mcycle/minstret.
module tb_ysyx_22041752_csr_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exc_valid, exc_is_int, mret, instret;
    logic [3:0]  exc_code;
    logic [63:0] exc_pc, exc_tval;
    logic [63:0] trap_pc, mret_pc;
    logic [2:0]  irq_i;
    logic        int_req;
    logic [3:0]  int_code;

    int tests_run = 0;
    int fails = 0;

    ysyx_22041752_csr_unit_if #(.XLEN(64)) bus ();

    ysyx_22041752_csr_unit #(.XLEN(64), .VECTOR_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .csr_bus(bus),
        .exc_valid(exc_valid), .exc_is_int(exc_is_int), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret),
        .trap_pc(trap_pc), .mret_pc(mret_pc), .irq_i(irq_i),
        .int_req(int_req), .int_code(int_code), .instret(instret)
    );

    always #5 clk = ~clk;

    // Reference model: architectural CSR contents.
    bit          m_mie_b, m_mpie_b;
    logic [63:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [2:0]  m_irq;
    logic [63:0] m_mcycle, m_minstret;

    task automatic model_reset();
        m_mie_b = 0; m_mpie_b = 0;
        m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_irq = 0; m_mcycle = 0; m_minstret = 0;
    endtask

    function automatic logic [63:0] mip_value();
        return (m_irq[0] ? 64'd8 : 64'd0) + (m_irq[1] ? 64'd128 : 64'd0) + (m_irq[2] ? 64'd2048 : 64'd0);
    endfunction

    function automatic logic [63:0] model_read(input logic [11:0] a, output bit ok);
        ok = 1;
        case (a)
            12'h300: return 64'hA_0000_1800 + (m_mie_b ? 64'd8 : 64'd0) + (m_mpie_b ? 64'd128 : 64'd0);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return mip_value();
`ifdef YSYX_22041752_CSR_COUNTERS_EN
            12'hB00: return m_mcycle;
            12'hB02: return m_minstret;
`endif
            default: begin ok = 0; return 64'd0; end
        endcase
    endfunction

    function automatic logic [3:0] model_int_code();
        logic [63:0] p;
        p = mip_value() & m_mie;
        if (p[11]) return 4'd11;
        if (p[3])  return 4'd3;
        if (p[7])  return 4'd7;
        return 4'd0;
    endfunction

    function automatic logic model_int_req();
        return m_mie_b && ((mip_value() & m_mie) != 0);
    endfunction

    function automatic logic [63:0] model_trap_pc();
        logic [63:0] base;
        base = m_mtvec & ~64'd3;
        if (m_mtvec[1:0] == 2'b01 && exc_is_int) return base + 64'd4 * exc_code;
        return base;
    endfunction

    task automatic model_step();
        bit ok, we;
        logic [63:0] old, nv;
        logic [11:0] a;
        a   = bus.csr_addr;
        old = model_read(a, ok);
        case (bus.csr_op)
            2'b01:   nv = bus.csr_wdata;
            2'b10:   nv = old | bus.csr_wdata;
            2'b11:   nv = old & ~bus.csr_wdata;
            default: nv = old;
        endcase
        we = bus.csr_en && ok && bus.csr_op != 2'b00;
        m_mcycle   = (we && a == 12'hB00) ? nv : m_mcycle + 1;
        m_minstret = (we && a == 12'hB02) ? nv : m_minstret + (instret ? 64'd1 : 64'd0);
        if (we && a == 12'h304) m_mie = nv;
        if (we && a == 12'h305) m_mtvec = nv;
        if (we && a == 12'h340) m_mscratch = nv;
        if (exc_valid) begin
            m_mepc   = exc_pc & ~64'd3;
            m_mcause = (exc_is_int ? 64'h8000_0000_0000_0000 : 64'd0) + exc_code;
            m_mtval  = exc_tval;
            m_mpie_b = m_mie_b;
            m_mie_b  = 0;
        end else begin
            if (we && a == 12'h341) m_mepc = nv & ~64'd3;
            if (we && a == 12'h342) m_mcause = nv;
            if (we && a == 12'h343) m_mtval = nv;
            if (mret) begin
                m_mie_b  = m_mpie_b;
                m_mpie_b = 1;
            end else if (we && a == 12'h300) begin
                m_mie_b  = nv[3];
                m_mpie_b = nv[7];
            end
        end
        m_irq = irq_i;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // Drive one cycle's inputs on the falling edge; strobes default low.
    task automatic drive(input logic en, input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd);
        @(negedge clk);
        bus.csr_en = en; bus.csr_op = op; bus.csr_addr = addr; bus.csr_wdata = wd;
        exc_valid = 0; exc_is_int = 0; exc_code = 0; exc_pc = 0; exc_tval = 0;
        mret = 0; instret = 0;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd);
        drive(1'b1, op, addr, wd);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr);
        drive(1'b1, 2'b00, addr, 64'd0);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [7] = '{12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344};
        reset_n = 0;
        bus.csr_en = 0; bus.csr_op = 0; bus.csr_addr = 12'h300; bus.csr_wdata = 0;
        exc_valid = 0; exc_is_int = 0; exc_code = 0; exc_pc = 0; exc_tval = 0;
        mret = 0; instret = 0; irq_i = 0;
        #3;
        tests_run++;
        if (bus.csr_rdata !== 64'hA_0000_1800) begin fails++; $display("FAIL reset_mstatus got=%h exp=%h", bus.csr_rdata, 64'hA_0000_1800); end
        tests_run++;
        if ({int_req, int_code, bus.csr_illegal} !== 6'd0) begin fails++; $display("FAIL reset_outputs got=%b exp=0", {int_req, int_code, bus.csr_illegal}); end
        tests_run++;
        if (trap_pc !== 64'd0 || mret_pc !== 64'd0) begin fails++; $display("FAIL reset_pcs got=%h/%h exp=0", trap_pc, mret_pc); end
        @(negedge clk);
        reset_n = 1;
        foreach (addrs[i]) begin
            rd(addrs[i]);
            tests_run++;
            if (bus.csr_rdata !== 64'd0) begin fails++; $display("FAIL reset_csr_%h got=%h exp=0", addrs[i], bus.csr_rdata); end
        end
    endtask

    task automatic test_illegal();
        bit ok;
        rd(12'h7C0);
        tests_run++;
        if (bus.csr_illegal !== 1'b1 || bus.csr_rdata !== 64'd0) begin fails++; $display("FAIL illegal_7c0 got=%b/%h exp=1/0", bus.csr_illegal, bus.csr_rdata); end
        wr(2'b01, 12'h7C0, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'h340);
        tests_run++;
        if (bus.csr_illegal !== 1'b0 || bus.csr_rdata !== model_read(12'h340, ok)) begin fails++; $display("FAIL illegal_nowrite got=%h exp=%h", bus.csr_rdata, model_read(12'h340, ok)); end
`ifndef YSYX_22041752_CSR_COUNTERS_EN
        rd(12'hB00);
        tests_run++;
        if (bus.csr_illegal !== 1'b1 || bus.csr_rdata !== 64'd0) begin fails++; $display("FAIL illegal_mcycle got=%b/%h exp=1/0", bus.csr_illegal, bus.csr_rdata); end
`endif
    endtask

    task automatic test_vectored_irq();
        wr(2'b01, 12'h305, 64'h8000_0001);
        wr(2'b10, 12'h304, 64'h80);
        wr(2'b10, 12'h300, 64'h8);
        drive(1'b0, 2'b00, 12'h300, 64'd0);
        irq_i = 3'b010;
        #1;
        tests_run++;
        if (int_req !== 1'b0) begin fails++; $display("FAIL irq_latency_early got=%b exp=0", int_req); end
        drive(1'b0, 2'b00, 12'h300, 64'd0);
        #1;
        tests_run++;
        if (int_req !== 1'b1 || int_code !== 4'd7) begin fails++; $display("FAIL irq_timer got=%b/%0d exp=1/7", int_req, int_code); end
        drive(1'b0, 2'b00, 12'h300, 64'd0);
        exc_valid = 1; exc_is_int = 1; exc_code = 4'd7; exc_pc = 64'h8000_0040; exc_tval = 0;
        #1;
        tests_run++;
        if (trap_pc !== 64'h8000_001C) begin fails++; $display("FAIL vectored_trap_pc got=%h exp=%h", trap_pc, 64'h8000_001C); end
        rd(12'h342);
        tests_run++;
        if (bus.csr_rdata !== 64'h8000_0000_0000_0007) begin fails++; $display("FAIL irq_mcause got=%h exp=%h", bus.csr_rdata, 64'h8000_0000_0000_0007); end
        rd(12'h300);
        tests_run++;
        if (bus.csr_rdata !== 64'hA_0000_1880 || int_req !== 1'b0) begin fails++; $display("FAIL irq_mstatus got=%h/%b exp=%h/0", bus.csr_rdata, int_req, 64'hA_0000_1880); end
        irq_i = 3'b000;
    endtask

    task automatic test_priority();
        irq_i = 3'b111;
        wr(2'b01, 12'h304, 64'h888);
        wr(2'b10, 12'h300, 64'h8);
        drive(1'b0, 2'b00, 12'h300, 64'd0);
        #1;
        tests_run++;
        if (int_req !== 1'b1 || int_code !== 4'd11) begin fails++; $display("FAIL prio_ext got=%b/%0d exp=1/11", int_req, int_code); end
        wr(2'b11, 12'h304, 64'h800);
        drive(1'b0, 2'b00, 12'h300, 64'd0);
        #1;
        tests_run++;
        if (int_code !== 4'd3) begin fails++; $display("FAIL prio_sw got=%0d exp=3", int_code); end
        wr(2'b11, 12'h304, 64'h8);
        drive(1'b0, 2'b00, 12'h300, 64'd0);
        #1;
        tests_run++;
        if (int_code !== 4'd7) begin fails++; $display("FAIL prio_timer got=%0d exp=7", int_code); end
        irq_i = 3'b000;
    endtask

    task automatic test_exc_vs_write();
        drive(1'b1, 2'b01, 12'h341, 64'h1234);
        exc_valid = 1; exc_is_int = 0; exc_code = 4'd2; exc_pc = 64'h8000_0100; exc_tval = 64'hDEAD;
        #1;
        tests_run++;
        if (trap_pc !== 64'h8000_0000) begin fails++; $display("FAIL exc_trap_pc got=%h exp=%h", trap_pc, 64'h8000_0000); end
        rd(12'h341);
        tests_run++;
        if (bus.csr_rdata !== 64'h8000_0100) begin fails++; $display("FAIL exc_over_write got=%h exp=%h", bus.csr_rdata, 64'h8000_0100); end
        rd(12'h343);
        tests_run++;
        if (bus.csr_rdata !== 64'hDEAD) begin fails++; $display("FAIL exc_mtval got=%h exp=%h", bus.csr_rdata, 64'hDEAD); end
        drive(1'b1, 2'b01, 12'h340, 64'h55);
        exc_valid = 1; exc_code = 4'd5; exc_pc = 64'h8000_0202;
        #1;
        rd(12'h340);
        tests_run++;
        if (bus.csr_rdata !== 64'h55) begin fails++; $display("FAIL exc_other_write got=%h exp=55", bus.csr_rdata); end
    endtask

    task automatic test_mret_and_reset();
        wr(2'b01, 12'h300, 64'h80);
        drive(1'b1, 2'b01, 12'h300, 64'd0);
        mret = 1;
        #1;
        tests_run++;
        if (mret_pc !== 64'h8000_0200) begin fails++; $display("FAIL mret_pc got=%h exp=%h", mret_pc, 64'h8000_0200); end
        rd(12'h300);
        tests_run++;
        if (bus.csr_rdata !== 64'hA_0000_1888) begin fails++; $display("FAIL mret_mstatus got=%h exp=%h", bus.csr_rdata, 64'hA_0000_1888); end
        wr(2'b01, 12'h340, 64'hABC);
        reset_n = 0;
        bus.csr_addr = 12'h300;
        #1;
        tests_run++;
        if (bus.csr_rdata !== 64'hA_0000_1800) begin fails++; $display("FAIL async_reset_mstatus got=%h exp=%h", bus.csr_rdata, 64'hA_0000_1800); end
        bus.csr_addr = 12'h340;
        #1;
        tests_run++;
        if (bus.csr_rdata !== 64'd0 || mret_pc !== 64'd0) begin fails++; $display("FAIL async_reset_abort got=%h/%h exp=0/0", bus.csr_rdata, mret_pc); end
        bus.csr_en = 0;
        reset_n = 1;
    endtask

    task automatic test_random();
        logic [11:0] pool [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'h344, 12'hB00, 12'hB02, 12'h7C0, 12'h300};
        bit ok;
        logic [63:0] e_rd;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  (n % 7 == 6) ? 12'($urandom) : pool[$urandom_range(0, 11)],
                  ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'(1 << $urandom_range(0, 11)));
            exc_valid  = ($urandom_range(0, 7) == 0);
            exc_is_int = $urandom_range(0, 1);
            exc_code   = 4'($urandom);
            exc_pc     = {$urandom, $urandom};
            exc_tval   = {$urandom, $urandom};
            mret       = ($urandom_range(0, 7) == 0);
            instret    = $urandom_range(0, 1);
            irq_i      = 3'($urandom);
            #1;
            e_rd = model_read(bus.csr_addr, ok);
            tests_run++;
            if (bus.csr_rdata !== e_rd) begin fails++; $display("FAIL rnd_rdata n=%0d addr=%h got=%h exp=%h", n, bus.csr_addr, bus.csr_rdata, e_rd); end
            tests_run++;
            if (bus.csr_illegal !== (bus.csr_en && !ok)) begin fails++; $display("FAIL rnd_illegal n=%0d got=%b exp=%b", n, bus.csr_illegal, bus.csr_en && !ok); end
            tests_run++;
            if (int_req !== model_int_req() || int_code !== model_int_code()) begin fails++; $display("FAIL rnd_int n=%0d got=%b/%0d exp=%b/%0d", n, int_req, int_code, model_int_req(), model_int_code()); end
            tests_run++;
            if (trap_pc !== model_trap_pc() || mret_pc !== m_mepc) begin fails++; $display("FAIL rnd_pcs n=%0d got=%h/%h exp=%h/%h", n, trap_pc, mret_pc, model_trap_pc(), m_mepc); end
        end
        irq_i = 0;
    endtask

`ifdef YSYX_22041752_CSR_COUNTERS_EN
    task automatic test_counters();
        wr(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, 2'b00, 12'hB00, 64'd0);
        rd(12'hB00);
        tests_run++;
        if (bus.csr_rdata !== 64'd0) begin fails++; $display("FAIL mcycle_wrap got=%h exp=0", bus.csr_rdata); end
        wr(2'b01, 12'hB02, 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 12'hB02, 64'd0);
            instret = 1;
        end
        rd(12'hB02);
        tests_run++;
        if (bus.csr_rdata !== 64'd3) begin fails++; $display("FAIL minstret_count got=%h exp=3", bus.csr_rdata); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_illegal();
        test_vectored_irq();
        test_priority();
        test_exc_vs_write();
        test_mret_and_reset();
        test_random();
`ifdef YSYX_22041752_CSR_COUNTERS_EN
        test_counters();
`endif
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
